// File: rtl/mc_decoder.sv
// mc_decoder: multi-cycle control FSM plus ALU/immediate decoders.
// Inputs:  clk, reset (sync, active-high), Op/Funct/Rd from the external
//          instruction register, MemReady memory handshake.
// Outputs: raw (unconditioned) sequencing controls, datapath mux selects,
//          ALUControl and FlagW.
module mc_decoder #(
  parameter int ALUCTL_W = 3,
  parameter bit EXT_OPS  = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          Op,
  input  logic [5:0]          Funct,
  input  logic [3:0]          Rd,
  input  logic                MemReady,
  output logic                IRWrite,
  output logic                NextPC,
  output logic                RegW,
  output logic                MemW,
  output logic                Branch,
  output logic                PCS,
  output logic                Link,
  output logic                Illegal,
  output logic                AdrSrc,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ResultSrc,
  output logic [1:0]          ImmSrc,
  output logic [1:0]          RegSrc,
  output logic [1:0]          FlagW,
  output logic [ALUCTL_W-1:0] ALUControl
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_LINK, S_BRANCH, S_TRAP
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_nowrite;
  logic [2:0] w_alu_code;
  logic       w_alu_nowrite;
  logic       w_cmp;
  logic       w_exec;
  logic       w_flag1;

  assign w_exec = (r_state == S_EXECR) || (r_state == S_EXECI);

  // NoWrite is captured while executing and consumed in ALUWB, where the
  // instruction register may no longer be trusted to decode the same way.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_nowrite <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_exec)
        r_nowrite <= w_alu_nowrite;
      else if (r_state == S_ALUWB)
        r_nowrite <= 1'b0;
    end
  end

  // ALU operation decode from Funct[4:1]; unknown codes default to ADD
  // with the register write suppressed.
  always_comb begin
    w_alu_code    = 3'd0;
    w_alu_nowrite = 1'b0;
    w_cmp         = 1'b0;
    case (Funct[4:1])
      4'b1101: w_alu_code = 3'd4;
      4'b0100: w_alu_code = 3'd0;
      4'b0010: w_alu_code = 3'd1;
      4'b0000: w_alu_code = 3'd2;
      4'b1100: w_alu_code = 3'd3;
      4'b0001: begin
        if (EXT_OPS) w_alu_code = 3'd5;
        else         w_alu_nowrite = 1'b1;
      end
      4'b1010: begin
        if (EXT_OPS) begin
          w_alu_code    = 3'd1;
          w_alu_nowrite = 1'b1;
          w_cmp         = 1'b1;
        end else begin
          w_alu_nowrite = 1'b1;
        end
      end
      default: w_alu_nowrite = 1'b1;
    endcase
  end

  assign w_flag1 = Funct[0] | w_cmp;

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    if (MemReady) w_next = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b00:   w_next = Funct[5] ? S_EXECI : S_EXECR;
          2'b01:   w_next = S_MEMADR;
          2'b10:   w_next = Funct[4] ? S_LINK : S_BRANCH;
          default: w_next = EXT_OPS ? S_TRAP : S_FETCH;
        endcase
      end
      S_MEMADR:   w_next = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (MemReady) w_next = S_MEMWB;
      S_MEMWRITE: if (MemReady) w_next = S_FETCH;
      S_EXECR:    w_next = S_ALUWB;
      S_EXECI:    w_next = S_ALUWB;
      S_LINK:     w_next = S_BRANCH;
      S_MEMWB:    w_next = S_FETCH;
      S_ALUWB:    w_next = S_FETCH;
      S_BRANCH:   w_next = S_FETCH;
      S_TRAP:     w_next = S_FETCH;
      default:    w_next = S_FETCH;
    endcase
  end

  // State-driven outputs; sequencing strobes are squashed while in reset.
  always_comb begin
    IRWrite    = 1'b0;
    NextPC     = 1'b0;
    RegW       = 1'b0;
    MemW       = 1'b0;
    Branch     = 1'b0;
    PCS        = 1'b0;
    Link       = 1'b0;
    Illegal    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    FlagW      = 2'b00;
    ALUControl = '0;
    case (r_state)
      S_FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady;
        NextPC    = MemReady;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR:   ALUSrcB = 2'b01;
      S_MEMREAD:  AdrSrc  = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcB    = (r_state == S_EXECI) ? 2'b01 : 2'b00;
        ALUControl = ALUCTL_W'(w_alu_code);
        FlagW      = {w_flag1, w_flag1 & (w_alu_code == 3'd0 || w_alu_code == 3'd1)};
      end
      S_ALUWB:    RegW = ~r_nowrite;
      S_LINK: begin
        RegW = 1'b1;
        Link = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        Branch    = 1'b1;
      end
      S_TRAP:     Illegal = 1'b1;
      default: ;
    endcase

    // A register write landing on r15 redirects the PC.
    PCS = (r_state == S_BRANCH) ||
          (((r_state == S_MEMWB) || (r_state == S_ALUWB)) && (Rd == 4'hF) && RegW);

    if (reset) begin
      IRWrite = 1'b0;
      NextPC  = 1'b0;
      RegW    = 1'b0;
      MemW    = 1'b0;
      Branch  = 1'b0;
      PCS     = 1'b0;
      Link    = 1'b0;
      Illegal = 1'b0;
    end
  end

  // Immediate and register-source selects follow the opcode in every state.
  always_comb begin
    ImmSrc = 2'b00;
    RegSrc = 2'b00;
    case (Op)
      2'b01: begin
        ImmSrc = 2'b01;
        RegSrc = Funct[0] ? 2'b00 : 2'b10;
      end
      2'b10: begin
        ImmSrc = 2'b10;
        RegSrc = 2'b01;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_decoder.sv
// Testbench for mc_decoder: table of per-cycle vectors against hand-computed
// expected outputs, plus a hand-written reset-during-store-wait sequence.
// Expected word layout: {IRWrite,NextPC,RegW,MemW,Branch,PCS,Link,Illegal}_
//   AdrSrc_ALUSrcA_ALUSrcB_ResultSrc_ImmSrc_RegSrc_FlagW_ALUControl.
module tb_mc_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       MemReady;

  logic       irw1, npc1, rw1, mw1, br1, pcs1, lnk1, ill1, adr1, asa1;
  logic [1:0] asb1, rs1, imm1, rgs1, fw1;
  logic [2:0] alu1;
  logic       irw0, npc0, rw0, mw0, br0, pcs0, lnk0, ill0, adr0, asa0;
  logic [1:0] asb0, rs0, imm0, rgs0, fw0;
  logic [2:0] alu0;

  always #5 clk = ~clk;

  mc_decoder #(.ALUCTL_W(3), .EXT_OPS(1'b1)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .MemReady(MemReady),
    .IRWrite(irw1), .NextPC(npc1), .RegW(rw1), .MemW(mw1), .Branch(br1), .PCS(pcs1),
    .Link(lnk1), .Illegal(ill1), .AdrSrc(adr1), .ALUSrcA(asa1), .ALUSrcB(asb1),
    .ResultSrc(rs1), .ImmSrc(imm1), .RegSrc(rgs1), .FlagW(fw1), .ALUControl(alu1)
  );

  mc_decoder #(.ALUCTL_W(3), .EXT_OPS(1'b0)) dut0 (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .MemReady(MemReady),
    .IRWrite(irw0), .NextPC(npc0), .RegW(rw0), .MemW(mw0), .Branch(br0), .PCS(pcs0),
    .Link(lnk0), .Illegal(ill0), .AdrSrc(adr0), .ALUSrcA(asa0), .ALUSrcB(asb0),
    .ResultSrc(rs0), .ImmSrc(imm0), .RegSrc(rgs0), .FlagW(fw0), .ALUControl(alu0)
  );

  logic [22:0] act1, act0;
  assign act1 = {irw1, npc1, rw1, mw1, br1, pcs1, lnk1, ill1, adr1, asa1, asb1, rs1, imm1, rgs1, fw1, alu1};
  assign act0 = {irw0, npc0, rw0, mw0, br0, pcs0, lnk0, ill0, adr0, asa0, asb0, rs0, imm0, rgs0, fw0, alu0};

  typedef struct packed {
    logic        rst;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic        mr;
    logic [22:0] exp;
    logic        chk0;
    logic [22:0] exp0;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Drive one cycle of inputs mid-period, compare just after, let the next
  // rising edge advance the FSM.
  task automatic apply(input vec_t v, input string name);
    @(negedge clk);
    reset    = v.rst;
    Op       = v.op;
    Funct    = v.funct;
    Rd       = v.rd;
    MemReady = v.mr;
    #1;
    n_vec++;
    if (act1 !== v.exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", name, act1, v.exp);
    end
    if (v.chk0) begin
      n_vec++;
      if (act0 !== v.exp0) begin
        n_bad++;
        $display("FAIL %s(EXT_OPS=0): got %b want %b", name, act0, v.exp0);
      end
    end
  endtask

  localparam logic [22:0] Z = 23'b0;

  initial begin
    reset = 1'b1; Op = 2'b00; Funct = 6'b0; Rd = 4'h0; MemReady = 1'b1;
    repeat (2) @(posedge clk);

    // reset held: FETCH, strobes squashed
    tbl.push_back('{1'b1, 2'b00, 6'b001001, 4'h3, 1'b1, 23'b00000000_0_1_10_10_00_00_00_000, 1'b0, Z});
    // ADD reg, Rd=3
    tbl.push_back('{1'b0, 2'b00, 6'b001001, 4'h3, 1'b1, 23'b11000000_0_1_10_10_00_00_00_000, 1'b0, Z});
    tbl.push_back('{1'b0, 2'b00, 6'b001001, 4'h3, 1'b1, 23'b00000000_0_1_10_10_00_00_00_000, 1'b0, Z});
    tbl.push_back('{1'b0, 2'b00, 6'b001001, 4'h3, 1'b1, 23'b00000000_0_0_00_00_00_00_11_000, 1'b0, Z});
    tbl.push_back('{1'b0, 2'b00, 6'b001001, 4'h3, 1'b1, 23'b00100000_0_0_00_00_00_00_00_000, 1'b0, Z});
    // LDR with fetch wait and 2 MEMREAD wait cycles
    tbl.push_back('{1'b0, 2'b01, 6'b011001, 4'h2, 1'b0, 23'b00000000_0_1_10_10_01_00_00_000, 1'b0, Z});
    tbl.push_back('{1'b0, 2'b01, 6'b011001, 4'h2, 1'b1, 23'b11000000_0_1_10_10_01_00_00_000, 1'b0, Z});
    tbl.push_back('{1'b0, 2'b01, 6'b011001, 4'h2, 1'b1, 23'b00000000_0_1_10_10_01_00_00_000, 1'b0, Z});
    tbl.push_back('{1'b0, 2'b01, 6'b011001, 4'h2, 1'b1, 23'b00000000_0_0_01_00_01_00_00_000, 1'b0, Z});
    tbl.push_back('{1'b0, 2'b01, 6'b011001, 4'h2, 1'b0, 23'b00000000_1_0_00_00_01_00_00_000, 1'b0, Z});
    tbl.push_back('{1'b0, 2'b01, 6'b011001, 4'h2, 1'b0, 23'b00000000_1_0_00_00_01_00_00_000, 1'b0, Z});
    tbl.push_back('{1'b0, 2'b01, 6'b011001, 4'h2, 1'b1, 23'b00000000_1_0_00_00_01_00_00_000, 1'b0, Z});
    tbl.push_back('{1'b0, 2'b01, 6'b011001, 4'h2, 1'b1, 23'b00100000_0_0_00_01_01_00_00_000, 1'b0, Z});
    // STR, no wait
    tbl.push_back('{1'b0, 2'b01, 6'b011000, 4'h4, 1'b1, 23'b11000000_0_1_10_10_01_10_00_000, 1'b0, Z});
    tbl.push_back('{1'b0, 2'b01, 6'b011000, 4'h4, 1'b1, 23'b00000000_0_1_10_10_01_10_00_000, 1'b0, Z});
    tbl.push_back('{1'b0, 2'b01, 6'b011000, 4'h4, 1'b1, 23'b00000000_0_0_01_00_01_10_00_000, 1'b0, Z});
    tbl.push_back('{1'b0, 2'b01, 6'b011000, 4'h4, 1'b1, 23'b00010000_1_0_00_00_01_10_00_000, 1'b0, Z});
    // BL
    tbl.push_back('{1'b0, 2'b10, 6'b010000, 4'hE, 1'b1, 23'b11000000_0_1_10_10_10_01_00_000, 1'b0, Z});
    tbl.push_back('{1'b0, 2'b10, 6'b010000, 4'hE, 1'b1, 23'b00000000_0_1_10_10_10_01_00_000, 1'b0, Z});
    tbl.push_back('{1'b0, 2'b10, 6'b010000, 4'hE, 1'b1, 23'b00100010_0_0_00_00_10_01_00_000, 1'b0, Z});
    tbl.push_back('{1'b0, 2'b10, 6'b010000, 4'hE, 1'b1, 23'b00001100_0_0_01_10_10_01_00_000, 1'b0, Z});
    // B (no link)
    tbl.push_back('{1'b0, 2'b10, 6'b000000, 4'h0, 1'b1, 23'b11000000_0_1_10_10_10_01_00_000, 1'b0, Z});
    tbl.push_back('{1'b0, 2'b10, 6'b000000, 4'h0, 1'b1, 23'b00000000_0_1_10_10_10_01_00_000, 1'b0, Z});
    tbl.push_back('{1'b0, 2'b10, 6'b000000, 4'h0, 1'b1, 23'b00001100_0_0_01_10_10_01_00_000, 1'b0, Z});
    // MOV to PC
    tbl.push_back('{1'b0, 2'b00, 6'b011010, 4'hF, 1'b1, 23'b11000000_0_1_10_10_00_00_00_000, 1'b0, Z});
    tbl.push_back('{1'b0, 2'b00, 6'b011010, 4'hF, 1'b1, 23'b00000000_0_1_10_10_00_00_00_000, 1'b0, Z});
    tbl.push_back('{1'b0, 2'b00, 6'b011010, 4'hF, 1'b1, 23'b00000000_0_0_00_00_00_00_00_100, 1'b0, Z});
    tbl.push_back('{1'b0, 2'b00, 6'b011010, 4'hF, 1'b1, 23'b00100100_0_0_00_00_00_00_00_000, 1'b0, Z});
    // ORRS immediate: FlagW=10
    tbl.push_back('{1'b0, 2'b00, 6'b111001, 4'h1, 1'b1, 23'b11000000_0_1_10_10_00_00_00_000, 1'b0, Z});
    tbl.push_back('{1'b0, 2'b00, 6'b111001, 4'h1, 1'b1, 23'b00000000_0_1_10_10_00_00_00_000, 1'b0, Z});
    tbl.push_back('{1'b0, 2'b00, 6'b111001, 4'h1, 1'b1, 23'b00000000_0_0_01_00_00_00_10_011, 1'b0, Z});
    tbl.push_back('{1'b0, 2'b00, 6'b111001, 4'h1, 1'b1, 23'b00100000_0_0_00_00_00_00_00_000, 1'b0, Z});
    // CMP: both configurations
    tbl.push_back('{1'b0, 2'b00, 6'b010101, 4'h0, 1'b1, 23'b11000000_0_1_10_10_00_00_00_000, 1'b0, Z});
    tbl.push_back('{1'b0, 2'b00, 6'b010101, 4'h0, 1'b1, 23'b00000000_0_1_10_10_00_00_00_000, 1'b0, Z});
    tbl.push_back('{1'b0, 2'b00, 6'b010101, 4'h0, 1'b1, 23'b00000000_0_0_00_00_00_00_11_001, 1'b1, 23'b00000000_0_0_00_00_00_00_11_000});
    tbl.push_back('{1'b0, 2'b00, 6'b010101, 4'h0, 1'b1, 23'b00000000_0_0_00_00_00_00_00_000, 1'b1, 23'b00000000_0_0_00_00_00_00_00_000});
    // EORS: code 5 with EXT_OPS, otherwise undefined (no write)
    tbl.push_back('{1'b0, 2'b00, 6'b000011, 4'h5, 1'b1, 23'b11000000_0_1_10_10_00_00_00_000, 1'b0, Z});
    tbl.push_back('{1'b0, 2'b00, 6'b000011, 4'h5, 1'b1, 23'b00000000_0_1_10_10_00_00_00_000, 1'b0, Z});
    tbl.push_back('{1'b0, 2'b00, 6'b000011, 4'h5, 1'b1, 23'b00000000_0_0_00_00_00_00_10_101, 1'b1, 23'b00000000_0_0_00_00_00_00_11_000});
    tbl.push_back('{1'b0, 2'b00, 6'b000011, 4'h5, 1'b1, 23'b00100000_0_0_00_00_00_00_00_000, 1'b1, 23'b00000000_0_0_00_00_00_00_00_000});
    // undefined ALU code to r15: no write, no PCS
    tbl.push_back('{1'b0, 2'b00, 6'b001111, 4'hF, 1'b1, 23'b11000000_0_1_10_10_00_00_00_000, 1'b0, Z});
    tbl.push_back('{1'b0, 2'b00, 6'b001111, 4'hF, 1'b1, 23'b00000000_0_1_10_10_00_00_00_000, 1'b0, Z});
    tbl.push_back('{1'b0, 2'b00, 6'b001111, 4'hF, 1'b1, 23'b00000000_0_0_00_00_00_00_11_000, 1'b0, Z});
    tbl.push_back('{1'b0, 2'b00, 6'b001111, 4'hF, 1'b1, 23'b00000000_0_0_00_00_00_00_00_000, 1'b0, Z});
    // SUB immediate to r15 right after: NoWrite must have cleared
    tbl.push_back('{1'b0, 2'b00, 6'b100100, 4'hF, 1'b1, 23'b11000000_0_1_10_10_00_00_00_000, 1'b0, Z});
    tbl.push_back('{1'b0, 2'b00, 6'b100100, 4'hF, 1'b1, 23'b00000000_0_1_10_10_00_00_00_000, 1'b0, Z});
    tbl.push_back('{1'b0, 2'b00, 6'b100100, 4'hF, 1'b1, 23'b00000000_0_0_01_00_00_00_00_001, 1'b0, Z});
    tbl.push_back('{1'b0, 2'b00, 6'b100100, 4'hF, 1'b1, 23'b00100100_0_0_00_00_00_00_00_000, 1'b0, Z});
    // illegal opcode: one-cycle trap then fetch
    tbl.push_back('{1'b0, 2'b11, 6'b000000, 4'h0, 1'b1, 23'b11000000_0_1_10_10_00_00_00_000, 1'b0, Z});
    tbl.push_back('{1'b0, 2'b11, 6'b000000, 4'h0, 1'b1, 23'b00000000_0_1_10_10_00_00_00_000, 1'b0, Z});
    tbl.push_back('{1'b0, 2'b11, 6'b000000, 4'h0, 1'b1, 23'b00000001_0_0_00_00_00_00_00_000, 1'b0, Z});
    tbl.push_back('{1'b0, 2'b11, 6'b000000, 4'h0, 1'b1, 23'b11000000_0_1_10_10_00_00_00_000, 1'b0, Z});

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Reset asserted while a store waits on MemReady.
    apply('{1'b1, 2'b01, 6'b011000, 4'h4, 1'b1, 23'b00000000_0_1_10_10_01_10_00_000, 1'b0, Z}, "str_rst0");
    apply('{1'b0, 2'b01, 6'b011000, 4'h4, 1'b1, 23'b11000000_0_1_10_10_01_10_00_000, 1'b0, Z}, "str_fetch");
    apply('{1'b0, 2'b01, 6'b011000, 4'h4, 1'b1, 23'b00000000_0_1_10_10_01_10_00_000, 1'b0, Z}, "str_decode");
    apply('{1'b0, 2'b01, 6'b011000, 4'h4, 1'b1, 23'b00000000_0_0_01_00_01_10_00_000, 1'b0, Z}, "str_memadr");
    apply('{1'b0, 2'b01, 6'b011000, 4'h4, 1'b0, 23'b00010000_1_0_00_00_01_10_00_000, 1'b0, Z}, "str_wait1");
    apply('{1'b0, 2'b01, 6'b011000, 4'h4, 1'b0, 23'b00010000_1_0_00_00_01_10_00_000, 1'b0, Z}, "str_wait2");
    apply('{1'b1, 2'b01, 6'b011000, 4'h4, 1'b0, 23'b00000000_1_0_00_00_01_10_00_000, 1'b0, Z}, "str_rst_memw");
    apply('{1'b0, 2'b01, 6'b011000, 4'h4, 1'b0, 23'b00000000_0_1_10_10_01_10_00_000, 1'b0, Z}, "post_rst_fetch");
    apply('{1'b0, 2'b01, 6'b011000, 4'h4, 1'b1, 23'b11000000_0_1_10_10_01_10_00_000, 1'b0, Z}, "post_rst_fetch_rdy");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_decoder.md
MC_DECODER -- requirements
Module: mc_decoder

Interface
REQ-001 Parameter ALUCTL_W, default 3: ALUControl width; SHALL be >= 3.
REQ-002 Parameter EXT_OPS, default 1: enables EOR, CMP and the illegal-op trap.
REQ-003 clk  in  1  sole clock, all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 Op  in  2  instruction class; Funct  in  6  instr[25:20]; Rd  in  4  destination register.
REQ-006 MemReady  in  1  memory handshake; high = access completes this cycle.
REQ-007 IRWrite, NextPC, RegW, MemW, Branch, PCS, Link, Illegal  out  1 each  raw (unconditioned) controls.
REQ-008 AdrSrc, ALUSrcA  out  1 each; ALUSrcB, ResultSrc, ImmSrc, RegSrc, FlagW  out  2 each; ALUControl  out  ALUCTL_W.

Function
REQ-009 The block SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, LINK, BRANCH, TRAP; state-driven outputs depend only on the state register.
REQ-010 Unlisted state outputs SHALL be 0.
  - FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10; IRWrite=NextPC=MemReady.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcB=01.
  - MEMREAD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWRITE: AdrSrc=1, MemW=1.
  - EXECR: ALUSrcB=00, ALU decoder active.
  - EXECI: ALUSrcB=01, ALU decoder active.
  - ALUWB: RegW=1 unless NoWrite.
  - LINK: RegW=1, Link=1.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
  - TRAP: Illegal=1.
REQ-011 Transitions:
  - FETCH->DECODE only when MemReady=1, else hold.
  - DECODE: Op=00 and Funct[5]=1 -> EXECI; Op=00 and Funct[5]=0 -> EXECR; Op=01 -> MEMADR; Op=10 and Funct[4]=1 -> LINK; Op=10 and Funct[4]=0 -> BRANCH; Op=11 -> TRAP when EXT_OPS=1, else FETCH.
  - MEMADR: Funct[0]=1 -> MEMREAD, else MEMWRITE.
  - MEMREAD->MEMWB when MemReady, else hold.
  - MEMWRITE->FETCH when MemReady, else hold with MemW held high.
  - EXECR/EXECI -> ALUWB.
  - LINK -> BRANCH.
  - MEMWB, ALUWB, BRANCH, TRAP -> FETCH.
REQ-012 Op, Funct and Rd SHALL be sampled by the combinational logic each cycle; the instruction register is external and stable after FETCH.
REQ-013 ImmSrc and RegSrc SHALL be combinational from Op alone, in every state:
  - Op=00: ImmSrc=00, RegSrc=00.
  - Op=01: ImmSrc=01; RegSrc=10 if Funct[0]=0, else 00.
  - Op=10: ImmSrc=10, RegSrc=01.
  - Op=11: both 00.
REQ-014 ALU decoder, active only in EXECR/EXECI, decodes Funct[4:1]:
  - 1101 MOV -> 4.
  - 0100 ADD -> 0.
  - 0010 SUB -> 1.
  - 0000 AND -> 2.
  - 1100 ORR -> 3.
  - When EXT_OPS=1: 0001 EOR -> 5; 1010 CMP -> 1 with NoWrite=1.
  - Any other code -> 0 with NoWrite=1.
  - All values are zero-extended to ALUCTL_W.
REQ-015 In all other states ALUControl SHALL be 0 (address/PC add).
REQ-016 FlagW in EXECR/EXECI:
  - FlagW[1] = Funct[0], forced to 1 for CMP.
  - FlagW[0] = FlagW[1] AND (ALUControl is 0 or 1).
  - 00 in all other states.
REQ-017 NoWrite SHALL be registered in EXECR/EXECI and used in ALUWB; it is cleared on leaving ALUWB.
REQ-018 PCS SHALL be 1 in BRANCH, and 1 in MEMWB/ALUWB when Rd=1111 and RegW=1; 0 elsewhere.
REQ-019 Illegal SHALL pulse for exactly one cycle per illegal opcode.

Reset
REQ-020 While reset=1, next state SHALL be FETCH, and IRWrite, NextPC, RegW, MemW, Branch, PCS, Link and Illegal SHALL be forced to 0.
REQ-021 Reset asserted in any state, including a held MemReady wait, SHALL abort the instruction; FETCH is entered at the first clk edge with reset=1, and nothing further is written.
REQ-022 The first cycle after reset deasserts SHALL be FETCH with fetch outputs.

Verification
REQ-023 Scenario: ADD reg (Op=00, Funct=001001, Rd=0011), MemReady=1.
  - Response: FETCH, DECODE, EXECR (ALUControl=0, FlagW=11), ALUWB (RegW=1, PCS=0), FETCH; 4 cycles.
REQ-024 Scenario: LDR (Op=01, Funct=011001), MemReady low 2 cycles in MEMREAD.
  - Response: MEMREAD held 3 cycles with AdrSrc=1; then MEMWB with ResultSrc=01, RegW=1.
REQ-025 Scenario: BL (Op=10, Funct=010000).
  - Response: DECODE, LINK (RegW=1, Link=1), BRANCH (Branch=1, PCS=1), FETCH.
REQ-026 Scenario: CMP (Funct[4:1]=1010, Funct[0]=1) with EXT_OPS=1.
  - Response: ALUControl=1, FlagW=11, ALUWB with RegW=0.
  - With EXT_OPS=0: ALUControl=0, RegW=0.
REQ-027 Scenario: MOV to PC (Funct=011010, Rd=1111).
  - Response: ALUWB with RegW=1 and PCS=1.
REQ-028 Scenario: reset pulsed in MEMWRITE while MemReady=0.
  - Response: MemW=0 during reset; FETCH follows deassertion.
  - Scenario: Op=11 -> TRAP with Illegal=1 for one cycle, then FETCH.
